accel_mem_port: RTL and testbench
=================================

# accel_mem_port

Accelerator-side endpoint of the CPU↔accelerator memory interface.
- Decodes CPU memory-mapped writes (`cpu_wrt_en`/`cpu_addr`/`cpu_wrt_data`) into source, destination and control registers.
- On start, fetches one 512-bit block from CPU data memory over `accel_addr`/`accel_rd_data` and hands it to the hash core.
- Writes the 256-bit digest back into CPU data memory as 32-bit words over `accel_wrt_en`/`accel_addr`/`accel_wrt_data`.
- Sits between the CPU top and the SHA-256 core.

## Interface
- `ACCEL_BASE`, default 16'hF000: byte address of the MMIO window.
- `RESULT_WORDS`, default 8: number of digest words written back.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `cpu_wrt_en` in 1: CPU store strobe.
- `cpu_addr` in 16: CPU store byte address.
- `cpu_wrt_data` in 32: CPU store data.
- `accel_rd_data` in 512: CPU data memory read data, valid 1 cycle after `accel_addr`.
- `accel_addr` out 16: CPU data memory byte address, used for both reads and writes.
- `accel_wrt_en` out 1: CPU data memory write strobe.
- `accel_wrt_data` out 32: CPU data memory write data.
- `core_start` out 1: one-cycle start pulse to the hash core.
- `core_block` out 512: message block to the hash core.
- `core_done` in 1: one-cycle done pulse from the hash core.
- `core_digest` in 256: digest, valid in the `core_done` cycle.
- `busy` out 1: operation in progress.

## Operation
- MMIO registers, byte offsets from `ACCEL_BASE`:
  - 0x0 SRC: source address, bits [15:0].
  - 0x4 DST: destination address, bits [15:0].
  - 0x8 CTRL: writing 1 to bit 0 starts an operation.
  - Other offsets and other addresses are ignored.
- Register updates:
  - A write to SRC or DST while `busy`=1 is ignored.
  - A CTRL start while `busy`=1 is ignored.
- FSM states:
  - IDLE → FETCH on CTRL start.
  - FETCH → LATCH.
  - LATCH → KICK.
  - KICK → WAIT.
  - WAIT → WRITE on `core_done`.
  - WRITE: loops for `RESULT_WORDS` cycles, then → STATUS (macro on) or → IDLE.
  - STATUS → IDLE.
- Per-state behaviour:
  - FETCH: `accel_addr`=SRC.
  - LATCH: `core_block` ← `accel_rd_data`.
  - KICK: `core_start`=1.
  - WAIT: digest latched on `core_done`.
  - WRITE, word i (0..RESULT_WORDS-1): `accel_addr`=DST+4·i, modulo 2^16 (wraps past 16'hFFFC). `accel_wrt_data`=digest[255-32i -: 32], so word 0 is the most significant word.
- `core_done` outside WAIT is ignored.
- A CPU write to the MMIO window in the same cycle as a state transition is decoded normally, subject to the busy rules above.
- Reset values:
  - Outputs: `accel_addr`=0, `accel_wrt_en`=0, `accel_wrt_data`=0, `core_start`=0, `core_block`=0, `busy`=0.
  - Internal: SRC=0, DST=0, state IDLE.
- Reset mid-operation aborts immediately.
  - Partial writes already done stay in memory.
  - No further writes occur.
- `accel_addr` and `accel_wrt_data` are 0 in IDLE and WAIT.

## Timing
- CTRL start sampled at edge T (FSM registered at end of T).
- T+1: FETCH, `busy`=1, `accel_addr`=SRC.
- T+2: LATCH, `core_block` captured at the end of this cycle.
- T+3: KICK, `core_start`=1 for exactly one cycle, `core_block` stable.
- `core_block` holds its value until the next LATCH.
- `core_done` sampled high in cycle D:
  - D+1..D+RESULT_WORDS: `accel_wrt_en`=1, one word per cycle, back-to-back with no gaps.
  - D+RESULT_WORDS+1: STATUS write (macro on).
- `busy` falls in the cycle after the last write. That is D+10 with the macro on and D+9 with it off, at default `RESULT_WORDS`.
- Earliest next CTRL start accepted: the cycle in which `busy`=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `ACCEL_STATUS_WB_EN`.
- Defined:
  - After the last digest word, one extra write occurs: `accel_addr`=DST+4·RESULT_WORDS, `accel_wrt_data`=32'h0000_0001 (done flag), so CPU firmware can poll memory.
  - STATUS state exists.
- Undefined:
  - STATUS state does not exist.
  - FSM returns from the last WRITE directly to IDLE.
  - Total writes = `RESULT_WORDS`.

## Structure
- Shared package `accel_pkg`:
  - FSM state enum.
  - MMIO offset constants: `ACCEL_SRC_OFS`, `ACCEL_DST_OFS`, `ACCEL_CTRL_OFS`.
  - Status word constant `ACCEL_STATUS_DONE`.
  - Default `RESULT_WORDS`.
- One sub-module: `accel_mmio_regs`.
  - Decodes the address window, holds SRC/DST, generates the start pulse, applies the busy gating.
- FSM and datapath live in the top module.

## Test plan
- Reset → after one `rst` cycle, all outputs 0, `busy`=0; a `core_done` pulse produces no write.
- Basic op:
  - Stimulus: SRC=16'h0100, DST=16'h0200, CTRL=1, memory[0x0100] = a known 512-bit block, `core_done` 5 cycles after `core_start`, digest = 256'h0123…EF.
  - Required: `core_block` matches the block at `core_start`; 8 writes to 0x0200..0x021C, MSW first; status 1 written to 0x0220 (macro on); `busy` low after.
- Busy gating: CTRL=1 and DST=16'h0300 issued during WAIT → ignored; writeback still targets 0x0200; no second `core_start`.
- Address wrap: DST=16'hFFF0 → write addresses FFF0, FFF4, FFF8, FFFC, 0000, 0004, 0008, 000C, status at 0010.
- Reset mid-op: assert `rst` after the 3rd digest write → `accel_wrt_en`=0 the next cycle; state IDLE; SRC/DST = 0.
- Macro off: same as the basic op → exactly 8 writes; `busy` falls at D+9; no write to 0x0220.

Source files
------------

// File: rtl/accel_pkg.sv
// Shared definitions for the accelerator memory port.
// ACCEL_STATUS_WB_EN adds the STATUS state and the trailing done-flag write.
package accel_pkg;

  // MMIO register byte offsets from the window base
  localparam logic [15:0] ACCEL_SRC_OFS  = 16'h0000;
  localparam logic [15:0] ACCEL_DST_OFS  = 16'h0004;
  localparam logic [15:0] ACCEL_CTRL_OFS = 16'h0008;

  // Word written after the digest so firmware can poll memory
  localparam logic [31:0] ACCEL_STATUS_DONE = 32'h0000_0001;

  // Default number of digest words written back
  localparam int ACCEL_RESULT_WORDS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LATCH  = 3'd2,
    ST_KICK   = 3'd3,
    ST_WAIT   = 3'd4,
    ST_WRITE  = 3'd5
`ifdef ACCEL_STATUS_WB_EN
    , ST_STATUS = 3'd6
`endif
  } accel_state_e;

  // Word idx of the digest, word 0 being the most significant 32 bits
  function automatic logic [31:0] digest_word(input logic [255:0] d, input int unsigned idx);
    logic [255:0] t;
    t = d << (idx * 32);
    return t[255:224];
  endfunction

endpackage

// File: rtl/accel_mmio_regs.sv
// MMIO decode for the accelerator: SRC/DST registers and the start pulse.
// Writes to SRC/DST and CTRL starts are dropped while an operation is busy.
// ACCEL_STATUS_WB_EN does not affect this block.
module accel_mmio_regs
  import accel_pkg::*;
#(
  parameter logic [15:0] ACCEL_BASE = 16'hF000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cpu_wrt_en,
  input  logic [15:0] i_cpu_addr,
  input  logic [31:0] i_cpu_wrt_data,
  input  logic        i_busy,
  output logic [15:0] o_src,
  output logic [15:0] o_dst,
  output logic        o_start
);

  logic [15:0] r_src;
  logic [15:0] r_dst;
  logic        w_wr_src;
  logic        w_wr_dst;
  logic        w_wr_ctrl;
  logic        w_unused_hi;

  // Window decode, gated by busy so an in-flight operation keeps its operands
  always_comb begin
    w_wr_src  = i_cpu_wrt_en && !i_busy && (i_cpu_addr == 16'(ACCEL_BASE + ACCEL_SRC_OFS));
    w_wr_dst  = i_cpu_wrt_en && !i_busy && (i_cpu_addr == 16'(ACCEL_BASE + ACCEL_DST_OFS));
    w_wr_ctrl = i_cpu_wrt_en && !i_busy && (i_cpu_addr == 16'(ACCEL_BASE + ACCEL_CTRL_OFS));
  end

  // Address registers hold only the low 16 bits of the store data
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_src <= '0;
      r_dst <= '0;
    end else begin
      if (w_wr_src) r_src <= i_cpu_wrt_data[15:0];
      if (w_wr_dst) r_dst <= i_cpu_wrt_data[15:0];
    end
  end

  assign o_src       = r_src;
  assign o_dst       = r_dst;
  assign o_start     = w_wr_ctrl && i_cpu_wrt_data[0];
  assign w_unused_hi = ^i_cpu_wrt_data[31:16];

endmodule

// File: rtl/accel_mem_port.sv
// Accelerator-side memory port: fetch one 512-bit block, run the hash core,
// write the 256-bit digest back as 32-bit words, most significant first.
// ACCEL_STATUS_WB_EN adds one extra write of ACCEL_STATUS_DONE after the digest.
// Every output is a flop; the next value is derived from the next FSM state.
module accel_mem_port
  import accel_pkg::*;
#(
  parameter logic [15:0] ACCEL_BASE   = 16'hF000,
  parameter int          RESULT_WORDS = ACCEL_RESULT_WORDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cpu_wrt_en,
  input  logic [15:0]  cpu_addr,
  input  logic [31:0]  cpu_wrt_data,
  input  logic [511:0] accel_rd_data,
  output logic [15:0]  accel_addr,
  output logic         accel_wrt_en,
  output logic [31:0]  accel_wrt_data,
  output logic         core_start,
  output logic [511:0] core_block,
  input  logic         core_done,
  input  logic [255:0] core_digest,
  output logic         busy,
  output logic [2:0]   dbg_state
);

  localparam int IW = (RESULT_WORDS > 1) ? $clog2(RESULT_WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(RESULT_WORDS - 1);

  accel_state_e r_state;
  accel_state_e w_next_state;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] w_next_idx;
  logic [255:0]  r_digest;
  logic [255:0]  w_next_digest;

  logic [15:0]  w_src;
  logic [15:0]  w_dst;
  logic         w_start;

  logic [15:0]  w_nxt_addr;
  logic         w_nxt_wen;
  logic [31:0]  w_nxt_wdata;

  logic [15:0]  r_accel_addr;
  logic         r_accel_wrt_en;
  logic [31:0]  r_accel_wrt_data;
  logic         r_core_start;
  logic [511:0] r_core_block;
  logic         r_busy;

  accel_mmio_regs #(
    .ACCEL_BASE(ACCEL_BASE)
  ) u_regs (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_cpu_wrt_en  (cpu_wrt_en),
    .i_cpu_addr    (cpu_addr),
    .i_cpu_wrt_data(cpu_wrt_data),
    .i_busy        (r_busy),
    .o_src         (w_src),
    .o_dst         (w_dst),
    .o_start       (w_start)
  );

  // Next-state logic; the digest is captured on the core_done cycle only in WAIT
  always_comb begin
    w_next_state  = r_state;
    w_next_idx    = r_idx;
    w_next_digest = r_digest;
    case (r_state)
      ST_IDLE:  if (w_start) w_next_state = ST_FETCH;
      ST_FETCH: w_next_state = ST_LATCH;
      ST_LATCH: w_next_state = ST_KICK;
      ST_KICK:  w_next_state = ST_WAIT;
      ST_WAIT: begin
        if (core_done) begin
          w_next_state  = ST_WRITE;
          w_next_idx    = '0;
          w_next_digest = core_digest;
        end
      end
      ST_WRITE: begin
        if (r_idx == LAST_IDX) begin
`ifdef ACCEL_STATUS_WB_EN
          w_next_state = ST_STATUS;
`else
          w_next_state = ST_IDLE;
`endif
        end else begin
          w_next_idx = r_idx + 1'b1;
        end
      end
`ifdef ACCEL_STATUS_WB_EN
      ST_STATUS: w_next_state = ST_IDLE;
`endif
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Memory-side output values for the cycle that the next state occupies
  always_comb begin
    w_nxt_addr  = '0;
    w_nxt_wen   = 1'b0;
    w_nxt_wdata = '0;
    case (w_next_state)
      ST_FETCH: w_nxt_addr = w_src;
      ST_WRITE: begin
        w_nxt_addr  = w_dst + (16'(w_next_idx) << 2);
        w_nxt_wen   = 1'b1;
        w_nxt_wdata = digest_word(w_next_digest, 32'(w_next_idx));
      end
`ifdef ACCEL_STATUS_WB_EN
      ST_STATUS: begin
        w_nxt_addr  = w_dst + 16'(RESULT_WORDS * 4);
        w_nxt_wen   = 1'b1;
        w_nxt_wdata = ACCEL_STATUS_DONE;
      end
`endif
      default: ;
    endcase
  end

  // State, write-back bookkeeping and registered outputs; reset aborts at once
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= ST_IDLE;
      r_idx            <= '0;
      r_digest         <= '0;
      r_accel_addr     <= '0;
      r_accel_wrt_en   <= 1'b0;
      r_accel_wrt_data <= '0;
      r_core_start     <= 1'b0;
      r_core_block     <= '0;
      r_busy           <= 1'b0;
    end else begin
      r_state          <= w_next_state;
      r_idx            <= w_next_idx;
      r_digest         <= w_next_digest;
      r_accel_addr     <= w_nxt_addr;
      r_accel_wrt_en   <= w_nxt_wen;
      r_accel_wrt_data <= w_nxt_wdata;
      r_core_start     <= (w_next_state == ST_KICK);
      r_busy           <= (w_next_state != ST_IDLE);
      if (r_state == ST_LATCH) r_core_block <= accel_rd_data;
    end
  end

  assign accel_addr     = r_accel_addr;
  assign accel_wrt_en   = r_accel_wrt_en;
  assign accel_wrt_data = r_accel_wrt_data;
  assign core_start     = r_core_start;
  assign core_block     = r_core_block;
  assign busy           = r_busy;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_accel_mem_port.sv
// Bench for accel_mem_port: timeline model of the operation, per-cycle compare
// of every output, plus directed literal expectations.
module tb_accel_mem_port;
  import accel_pkg::*;

  localparam logic [15:0] BASE = 16'hF000;
  localparam int RW = 8;
`ifdef ACCEL_STATUS_WB_EN
  localparam int NW = RW + 1;
  localparam int FALL_LIT = 10;
  localparam int STAT_CNT = 1;
`else
  localparam int NW = RW;
  localparam int FALL_LIT = 9;
  localparam int STAT_CNT = 0;
`endif

  localparam logic [511:0] BLK = 512'h00010203_04050607_08090A0B_0C0D0E0F_10111213_14151617_18191A1B_1C1D1E1F_20212223_24252627_28292A2B_2C2D2E2F_30313233_34353637_38393A3B_3C3D3E3F;
  localparam logic [255:0] DIG = 256'h01234567_11111111_22222222_33333333_44444444_55555555_66666666_89ABCDEF;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cpu_wrt_en = 1'b0;
  logic [15:0]  cpu_addr = '0;
  logic [31:0]  cpu_wrt_data = '0;
  logic [511:0] accel_rd_data = '0;
  logic         core_done = 1'b0;
  logic [255:0] core_digest = '0;
  logic [15:0]  accel_addr;
  logic         accel_wrt_en;
  logic [31:0]  accel_wrt_data;
  logic         core_start;
  logic [511:0] core_block;
  logic         busy;
  logic [2:0]   dbg_state;

  always #5 clk = ~clk;

  accel_mem_port #(.ACCEL_BASE(BASE), .RESULT_WORDS(RW)) dut (
    .clk(clk), .rst(rst), .cpu_wrt_en(cpu_wrt_en), .cpu_addr(cpu_addr),
    .cpu_wrt_data(cpu_wrt_data), .accel_rd_data(accel_rd_data),
    .accel_addr(accel_addr), .accel_wrt_en(accel_wrt_en),
    .accel_wrt_data(accel_wrt_data), .core_start(core_start),
    .core_block(core_block), .core_done(core_done), .core_digest(core_digest),
    .busy(busy), .dbg_state(dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // CPU data memory: read data one cycle after the address
  logic [511:0] mem [logic [15:0]];
  function automatic logic [511:0] mem_rd(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return '0;
  endfunction
  always @(posedge clk) accel_rd_data <= mem_rd(accel_addr);

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;
  int n_starts = 0;
  logic [15:0] log_a[$];
  logic [31:0] log_d[$];

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // One operation = timeline: start accepted at cycle t, done seen at cycle d.
  // Fetch address at t+1, block valid from t+3, start pulse at t+3,
  // writes at d+1..d+NW, busy from t+1 through the last write.
  bit           m_active = 1'b0;
  int           m_t = 0;
  int           m_d = -1;
  logic [15:0]  m_src = '0, m_dst = '0, m_src_snap = '0;
  logic [255:0] m_dig = '0;
  logic [511:0] m_blk = '0;

  initial forever begin : model
    bit was_busy;
    @(posedge clk);
    if (rst) begin
      m_active = 1'b0; m_d = -1; m_src = '0; m_dst = '0; m_blk = '0;
    end else begin
      was_busy = m_active;
      if (m_active && m_d < 0 && cyc >= m_t + 4 && core_done) begin
        m_d = cyc;
        m_dig = core_digest;
      end
      if (m_active && cyc == m_t + 2) m_blk = mem_rd(m_src_snap);
      if (m_active && m_d >= 0 && cyc == m_d + NW) m_active = 1'b0;
      if (cpu_wrt_en && !was_busy) begin
        if (cpu_addr == BASE) m_src = cpu_wrt_data[15:0];
        else if (cpu_addr == BASE + 16'h4) m_dst = cpu_wrt_data[15:0];
        else if (cpu_addr == BASE + 16'h8 && cpu_wrt_data[0]) begin
          m_active = 1'b1; m_t = cyc; m_d = -1; m_src_snap = m_src;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin : compare
    logic [15:0]  e_addr;
    logic [31:0]  e_data;
    logic [255:0] sh;
    bit           e_wen;
    bit           e_start;
    int           i;
    @(negedge clk);
    if (accel_wrt_en) begin log_a.push_back(accel_addr); log_d.push_back(accel_wrt_data); end
    if (core_start) n_starts++;
    if (chk_en) begin
      e_addr = '0; e_data = '0; e_wen = 1'b0;
      if (m_active && m_d >= 0 && cyc > m_d && cyc <= m_d + NW) begin
        e_wen  = 1'b1;
        i      = cyc - m_d - 1;
        e_addr = 16'(m_dst + 4 * i);
        if (i < RW) begin
          sh = m_dig >> (32 * (RW - 1 - i));
          e_data = sh[31:0];
        end else begin
          e_data = 32'h1;
        end
      end else if (m_active && cyc == m_t + 1) begin
        e_addr = m_src_snap;
      end
      e_start = m_active && (cyc == m_t + 3);
      chk("busy", busy, m_active);
      chk("wrt_en", accel_wrt_en, e_wen);
      chk("addr", accel_addr, e_addr);
      chk("wrt_data", accel_wrt_data, e_data);
      chk("core_start", core_start, e_start);
      chk("core_block", core_block, m_blk);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cpu_write(input logic [15:0] a, input logic [31:0] d);
    cpu_wrt_en = 1'b1; cpu_addr = a; cpu_wrt_data = d;
    @(posedge clk); #1;
    cpu_wrt_en = 1'b0; cpu_addr = '0; cpu_wrt_data = '0;
  endtask

  task automatic start_op(input logic [15:0] s, input logic [15:0] d);
    log_a.delete(); log_d.delete(); n_starts = 0;
    cpu_write(BASE, {16'h0, s});
    cpu_write(BASE + 16'h4, {16'h0, d});
    cpu_write(BASE + 16'h8, 32'h1);
  endtask

  // Waits for core_start, answers with core_done five cycles later
  task automatic run_done(input logic [255:0] dig, input logic [511:0] blk_exp,
                          input bit gate, output int d_cyc);
    int n;
    n = 0;
    while (!core_start && n < 20) begin @(posedge clk); #1; n++; end
    chk("start_timeout", core_start, 1'b1);
    chk("blk_at_start", core_block, blk_exp);
    if (gate) begin
      cpu_write(BASE + 16'h4, 32'h0000_0300);
      cpu_write(BASE + 16'h8, 32'h1);
      repeat (3) begin @(posedge clk); #1; end
    end else begin
      repeat (5) begin @(posedge clk); #1; end
    end
    core_done = 1'b1; core_digest = dig; d_cyc = cyc;
    @(posedge clk); #1;
    core_done = 1'b0; core_digest = '1;
  endtask

  task automatic wait_idle(output int fall);
    int n;
    n = 0;
    while (busy && n < 40) begin @(posedge clk); #1; n++; end
    chk("idle_timeout", busy, 1'b0);
    fall = cyc;
  endtask

  // ---------------- directed sequence ----------------
  logic [15:0] wrap_exp [9] = '{16'hFFF0, 16'hFFF4, 16'hFFF8, 16'hFFFC,
                                16'h0000, 16'h0004, 16'h0008, 16'h000C, 16'h0010};

  initial begin : stim
    int d, fall, hits;
    mem[16'h0100] = BLK;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // reset state and stray core_done
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_busy", busy, 1'b0);
    core_done = 1'b1; core_digest = DIG;
    @(posedge clk); #1;
    core_done = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("stray_done_writes", log_a.size(), 0);

    // ignored offsets and addresses outside the window
    cpu_write(BASE + 16'hC, 32'h1);
    cpu_write(16'h0008, 32'h1);
    @(posedge clk); #1;
    chk("ignored_ctrl", busy, 1'b0);

    // basic operation
    start_op(16'h0100, 16'h0200);
    run_done(DIG, BLK, 1'b0, d);
    wait_idle(fall);
    chk("basic_nwrites", log_a.size(), NW);
    if (log_a.size() == NW) begin
      chk("basic_a0", log_a[0], 16'h0200);
      chk("basic_d0", log_d[0], 32'h01234567);
      chk("basic_a7", log_a[7], 16'h021C);
      chk("basic_d7", log_d[7], 32'h89ABCDEF);
    end
    hits = 0;
    for (int i = 0; i < log_a.size(); i++)
      if (log_a[i] == 16'h0220 && log_d[i] == 32'h1) hits++;
    chk("status_write", hits, STAT_CNT);
    chk("busy_fall", fall - d, FALL_LIT);

    // busy gating: DST and CTRL written during WAIT
    start_op(16'h0100, 16'h0200);
    run_done(DIG, BLK, 1'b1, d);
    wait_idle(fall);
    chk("gate_starts", n_starts, 1);
    chk("gate_nwrites", log_a.size(), NW);
    if (log_a.size() > 0) chk("gate_a0", log_a[0], 16'h0200);

    // destination wrap past 16'hFFFC
    start_op(16'h0100, 16'hFFF0);
    run_done(DIG, BLK, 1'b0, d);
    wait_idle(fall);
    chk("wrap_nwrites", log_a.size(), NW);
    for (int i = 0; i < NW && i < log_a.size(); i++) chk("wrap_addr", log_a[i], wrap_exp[i]);

    // reset during write-back, with the third word on the bus
    start_op(16'h0100, 16'h0200);
    run_done(DIG, BLK, 1'b0, d);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_wen", accel_wrt_en, 1'b0);
    chk("abort_state", dbg_state, ST_IDLE);
    chk("abort_busy", busy, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    chk("abort_nwrites", log_a.size(), 3);

    // SRC/DST cleared by reset: start alone uses address 0
    log_a.delete(); log_d.delete();
    cpu_write(BASE + 16'h8, 32'h1);
    run_done(DIG, 512'h0, 1'b0, d);
    wait_idle(fall);
    chk("post_rst_nwrites", log_a.size(), NW);
    if (log_a.size() > 0) chk("post_rst_a0", log_a[0], 16'h0000);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1);
  end

endmodule
